// File: rtl/llc_sweep_ctrl.sv
// llc_sweep_ctrl: shares the LLC input decoder's pass trigger (decode_en) between
// normal traffic passes and reset/flush sweeps that walk every LLC set.
// Optional build macro LLC_SWEEP_TIMEOUT_EN adds a per-pass WAIT timeout with a
// sticky sweep_err output.
module llc_sweep_ctrl #(
  parameter int SET_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                norm_req_valid,
  output logic                norm_req_ready,
  input  logic                sweep_req_valid,
  input  logic                sweep_req_is_flush,
  output logic                sweep_req_ready,
  output logic                decode_en,
  input  logic                pass_done,
  input  logic                incr_rst_flush_stalled_set,
  input  logic                clr_rst_stall,
  input  logic                clr_flush_stall,
  output logic                rst_stall,
  output logic                flush_stall,
  output logic [SET_BITS-1:0] rst_flush_stalled_set,
  output logic                sweep_done,
`ifdef LLC_SWEEP_TIMEOUT_EN
  output logic                sweep_err,
`endif
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NORM_WAIT = 3'd1,
    SWP_ISSUE = 3'd2,
    SWP_WAIT  = 3'd3,
    SWP_DONE  = 3'd4
  } state_t;

  localparam logic [SET_BITS-1:0] SET_LAST = '1;

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic                rst_stall_q, rst_stall_d;
  logic                flush_stall_q, flush_stall_d;
  logic                decode_en_q, decode_en_d;
  logic                sweep_acc, norm_acc;
  logic                clr_match;

`ifdef LLC_SWEEP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             sweep_err_q, sweep_err_d;
  logic             in_wait;
  logic             tmo_hit;
`endif

  // Requests are only granted from IDLE and never while reset is asserted; sweep wins ties.
  assign sweep_req_ready = rst && (state_q == IDLE);
  assign norm_req_ready  = rst && (state_q == IDLE) && !sweep_req_valid;
  assign sweep_acc       = sweep_req_valid && sweep_req_ready;
  assign norm_acc        = norm_req_valid && norm_req_ready;

  // A sweep ends only on the clear that matches its own kind, and only at the last set.
  assign clr_match = (rst_stall_q && clr_rst_stall) || (flush_stall_q && clr_flush_stall);

  assign decode_en             = decode_en_q;
  assign rst_stall             = rst_stall_q;
  assign flush_stall           = flush_stall_q;
  assign rst_flush_stalled_set = set_q;
  assign sweep_done            = (state_q == SWP_DONE);
  assign busy                  = (state_q != IDLE);

`ifdef LLC_SWEEP_TIMEOUT_EN
  assign sweep_err = sweep_err_q;
  assign in_wait   = (state_q == NORM_WAIT) || (state_q == SWP_WAIT);
  assign tmo_hit   = in_wait && !pass_done && (tmo_cnt_q == TMO_LAST);

  // WAIT-cycle counter: restarts on every WAIT entry and saturates instead of wrapping.
  always_comb begin
    tmo_cnt_d = '0;
    if (in_wait) begin
      tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    end
  end
`endif

  // Next-state and next-control computation for the scheduler FSM.
  always_comb begin
    state_d       = state_q;
    set_d         = set_q;
    rst_stall_d   = rst_stall_q;
    flush_stall_d = flush_stall_q;
`ifdef LLC_SWEEP_TIMEOUT_EN
    sweep_err_d   = sweep_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (sweep_acc) begin
          set_d         = '0;
          rst_stall_d   = !sweep_req_is_flush;
          flush_stall_d = sweep_req_is_flush;
          state_d       = SWP_ISSUE;
        end else if (norm_acc) begin
          state_d = NORM_WAIT;
        end
      end
      NORM_WAIT: begin
        if (pass_done) state_d = IDLE;
      end
      SWP_ISSUE: begin
        state_d = SWP_WAIT;
      end
      SWP_WAIT: begin
        if (pass_done) begin
          if (incr_rst_flush_stalled_set) set_d = set_q + 1'b1;
          if ((set_q == SET_LAST) && clr_match) begin
            rst_stall_d   = 1'b0;
            flush_stall_d = 1'b0;
            state_d       = SWP_DONE;
          end else begin
            state_d = SWP_ISSUE;
          end
        end
      end
      SWP_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef LLC_SWEEP_TIMEOUT_EN
    // A decoder that never answers aborts the pass (and any sweep) without sweep_done.
    if (tmo_hit) begin
      state_d       = IDLE;
      set_d         = '0;
      rst_stall_d   = 1'b0;
      flush_stall_d = 1'b0;
      sweep_err_d   = 1'b1;
    end
`endif
    // decode_en is registered: one pulse per granted normal pass or per sweep ISSUE cycle.
    decode_en_d = norm_acc || (state_d == SWP_ISSUE);
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      set_q         <= '0;
      rst_stall_q   <= 1'b0;
      flush_stall_q <= 1'b0;
      decode_en_q   <= 1'b0;
`ifdef LLC_SWEEP_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      sweep_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      set_q         <= set_d;
      rst_stall_q   <= rst_stall_d;
      flush_stall_q <= flush_stall_d;
      decode_en_q   <= decode_en_d;
`ifdef LLC_SWEEP_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      sweep_err_q   <= sweep_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_llc_sweep_ctrl.sv
// Directed testbench for llc_sweep_ctrl (SET_BITS=2, TIMEOUT_CYCLES=8).
module tb_llc_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       norm_req_valid, norm_req_ready;
  logic       sweep_req_valid, sweep_req_is_flush, sweep_req_ready;
  logic       decode_en, pass_done, incr;
  logic       clr_rst_stall, clr_flush_stall;
  logic       rst_stall, flush_stall, sweep_done, busy;
  logic [1:0] set;
`ifdef LLC_SWEEP_TIMEOUT_EN
  logic       sweep_err;
`endif

  int checks   = 0;
  int failures = 0;

  llc_sweep_ctrl #(.SET_BITS(2), .TIMEOUT_CYCLES(8)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .norm_req_valid             (norm_req_valid),
    .norm_req_ready             (norm_req_ready),
    .sweep_req_valid            (sweep_req_valid),
    .sweep_req_is_flush         (sweep_req_is_flush),
    .sweep_req_ready            (sweep_req_ready),
    .decode_en                  (decode_en),
    .pass_done                  (pass_done),
    .incr_rst_flush_stalled_set (incr),
    .clr_rst_stall              (clr_rst_stall),
    .clr_flush_stall            (clr_flush_stall),
    .rst_stall                  (rst_stall),
    .flush_stall                (flush_stall),
    .rst_flush_stalled_set      (set),
    .sweep_done                 (sweep_done),
`ifdef LLC_SWEEP_TIMEOUT_EN
    .sweep_err                  (sweep_err),
`endif
    .busy                       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From SWP_ISSUE: wait dly extra cycles in WAIT, then answer the pass.
  task automatic do_pass(input logic i, input logic cr, input logic cf, input int dly);
    tick();
    repeat (dly) tick();
    pass_done = 1'b1; incr = i; clr_rst_stall = cr; clr_flush_stall = cf;
    tick();
    pass_done = 1'b0; incr = 1'b0; clr_rst_stall = 1'b0; clr_flush_stall = 1'b0;
  endtask

  // From IDLE: present a sweep request and leave the FSM in the first SWP_ISSUE cycle.
  task automatic start_sweep(input logic is_flush);
    sweep_req_valid = 1'b1; sweep_req_is_flush = is_flush;
    tick();
    sweep_req_valid = 1'b0; sweep_req_is_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; norm_req_valid = 1'b1; sweep_req_valid = 1'b1; sweep_req_is_flush = 1'b0;
    pass_done = 1'b0; incr = 1'b0; clr_rst_stall = 1'b0; clr_flush_stall = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (decode_en !== 1'b0) begin failures++; $display("FAIL reset_decode_en got=%0b exp=0", decode_en); end
    checks++; if ({rst_stall, flush_stall} !== 2'b00) begin failures++; $display("FAIL reset_stalls got=%b exp=00", {rst_stall, flush_stall}); end
    checks++; if (set !== 2'd0) begin failures++; $display("FAIL reset_set got=%0d exp=0", set); end
    checks++; if (sweep_done !== 1'b0) begin failures++; $display("FAIL reset_sweep_done got=%0b exp=0", sweep_done); end
    checks++; if ({sweep_req_ready, norm_req_ready} !== 2'b00) begin failures++; $display("FAIL reset_readies got=%b exp=00", {sweep_req_ready, norm_req_ready}); end
`ifdef LLC_SWEEP_TIMEOUT_EN
    checks++; if (sweep_err !== 1'b0) begin failures++; $display("FAIL reset_sweep_err got=%0b exp=0", sweep_err); end
`endif
    norm_req_valid = 1'b0; sweep_req_valid = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_sweep();
    sweep_req_valid = 1'b1; sweep_req_is_flush = 1'b0;
    #1;
    checks++; if (sweep_req_ready !== 1'b1) begin failures++; $display("FAIL t1_sweep_ready got=%0b exp=1", sweep_req_ready); end
    tick();
    sweep_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (decode_en !== 1'b1) begin failures++; $display("FAIL t1_decode_en pass=%0d got=%0b exp=1", i, decode_en); end
      checks++; if (set !== 2'(i)) begin failures++; $display("FAIL t1_set pass=%0d got=%0d exp=%0d", i, set, i); end
      checks++; if ({rst_stall, flush_stall} !== 2'b10) begin failures++; $display("FAIL t1_stalls pass=%0d got=%b exp=10", i, {rst_stall, flush_stall}); end
      tick();
      checks++; if (decode_en !== 1'b0) begin failures++; $display("FAIL t1_decode_pulse pass=%0d got=%0b exp=0", i, decode_en); end
      pass_done = 1'b1; incr = 1'b1; clr_rst_stall = (i == 3);
      if (i == 1) begin
        pass_done = 1'b0;
        tick();
        pass_done = 1'b1;
      end
      tick();
      pass_done = 1'b0; incr = 1'b0; clr_rst_stall = 1'b0;
    end
    checks++; if (sweep_done !== 1'b1) begin failures++; $display("FAIL t1_sweep_done got=%0b exp=1", sweep_done); end
    checks++; if (rst_stall !== 1'b0) begin failures++; $display("FAIL t1_rst_stall_end got=%0b exp=0", rst_stall); end
    checks++; if (set !== 2'd0) begin failures++; $display("FAIL t1_set_end got=%0d exp=0", set); end
    tick();
    checks++; if ({sweep_done, busy} !== 2'b00) begin failures++; $display("FAIL t1_idle got=%b exp=00", {sweep_done, busy}); end
  endtask

  task automatic test_tie();
    sweep_req_valid = 1'b1; norm_req_valid = 1'b1; sweep_req_is_flush = 1'b0;
    #1;
    checks++; if ({sweep_req_ready, norm_req_ready} !== 2'b10) begin failures++; $display("FAIL t2_tie_readies got=%b exp=10", {sweep_req_ready, norm_req_ready}); end
    tick();
    sweep_req_valid = 1'b0;
    #1;
    checks++; if (norm_req_ready !== 1'b0) begin failures++; $display("FAIL t2_norm_ready_busy got=%0b exp=0", norm_req_ready); end
    for (int i = 0; i < 4; i++) do_pass(1'b1, (i == 3), 1'b0, 0);
    checks++; if ({sweep_done, norm_req_ready} !== 2'b10) begin failures++; $display("FAIL t2_done got=%b exp=10", {sweep_done, norm_req_ready}); end
    tick();
    checks++; if (norm_req_ready !== 1'b1) begin failures++; $display("FAIL t2_norm_ready got=%0b exp=1", norm_req_ready); end
    tick();
    norm_req_valid = 1'b0;
    checks++; if ({decode_en, busy} !== 2'b11) begin failures++; $display("FAIL t2_norm_decode got=%b exp=11", {decode_en, busy}); end
    tick();
    checks++; if (decode_en !== 1'b0) begin failures++; $display("FAIL t2_norm_pulse got=%0b exp=0", decode_en); end
    pass_done = 1'b1; incr = 1'b1; clr_rst_stall = 1'b1;
    tick();
    pass_done = 1'b0; incr = 1'b0; clr_rst_stall = 1'b0;
    checks++; if ({busy, set, rst_stall, sweep_done} !== 5'b0_00_0_0) begin failures++; $display("FAIL t2_norm_end got=%b exp=00000", {busy, set, rst_stall, sweep_done}); end
  endtask

  task automatic test_flush_clr_filter();
    start_sweep(1'b1);
    checks++; if ({rst_stall, flush_stall} !== 2'b01) begin failures++; $display("FAIL t3_stalls got=%b exp=01", {rst_stall, flush_stall}); end
    do_pass(1'b1, 1'b0, 1'b0, 0);
    do_pass(1'b1, 1'b0, 1'b1, 0);
    checks++; if ({decode_en, set, flush_stall} !== 4'b1_10_1) begin failures++; $display("FAIL t3_early_clr got=%b exp=1101", {decode_en, set, flush_stall}); end
    do_pass(1'b1, 1'b0, 1'b0, 0);
    do_pass(1'b1, 1'b1, 1'b0, 1);
    checks++; if ({decode_en, set, flush_stall, sweep_done} !== 5'b1_00_1_0) begin failures++; $display("FAIL t3_wrong_clr got=%b exp=10010", {decode_en, set, flush_stall, sweep_done}); end
    for (int i = 0; i < 4; i++) do_pass(1'b1, 1'b0, (i == 3), 0);
    checks++; if ({sweep_done, rst_stall, flush_stall} !== 3'b100) begin failures++; $display("FAIL t3_done got=%b exp=100", {sweep_done, rst_stall, flush_stall}); end
    tick();
  endtask

  task automatic test_retry();
    start_sweep(1'b0);
    do_pass(1'b1, 1'b0, 1'b0, 0);
    do_pass(1'b1, 1'b0, 1'b0, 0);
    checks++; if (set !== 2'd2) begin failures++; $display("FAIL t4_set_before got=%0d exp=2", set); end
    do_pass(1'b0, 1'b0, 1'b0, 0);
    checks++; if ({decode_en, set} !== 3'b1_10) begin failures++; $display("FAIL t4_retry got=%b exp=110", {decode_en, set}); end
    do_pass(1'b1, 1'b0, 1'b0, 0);
    checks++; if (set !== 2'd3) begin failures++; $display("FAIL t4_set_after got=%0d exp=3", set); end
    do_pass(1'b1, 1'b1, 1'b0, 0);
    checks++; if (sweep_done !== 1'b1) begin failures++; $display("FAIL t4_done got=%0b exp=1", sweep_done); end
    tick();
  endtask

  task automatic test_mid_sweep_reset();
    start_sweep(1'b1);
    do_pass(1'b1, 1'b0, 1'b0, 0);
    do_pass(1'b1, 1'b0, 1'b0, 0);
    tick();
    checks++; if ({busy, set, flush_stall} !== 4'b1_10_1) begin failures++; $display("FAIL t5_pre got=%b exp=1101", {busy, set, flush_stall}); end
    rst = 1'b0; sweep_req_valid = 1'b1; norm_req_valid = 1'b1;
    tick();
    checks++; if ({flush_stall, set, busy, sweep_done} !== 5'b0_00_0_0) begin failures++; $display("FAIL t5_abort got=%b exp=00000", {flush_stall, set, busy, sweep_done}); end
    checks++; if ({sweep_req_ready, norm_req_ready} !== 2'b00) begin failures++; $display("FAIL t5_readies got=%b exp=00", {sweep_req_ready, norm_req_ready}); end
    tick();
    checks++; if ({sweep_done, decode_en, sweep_req_ready} !== 3'b000) begin failures++; $display("FAIL t5_hold got=%b exp=000", {sweep_done, decode_en, sweep_req_ready}); end
    rst = 1'b1;
    #1;
    checks++; if ({sweep_req_ready, norm_req_ready} !== 2'b10) begin failures++; $display("FAIL t5_release got=%b exp=10", {sweep_req_ready, norm_req_ready}); end
    sweep_req_valid = 1'b0; norm_req_valid = 1'b0;
    tick();
  endtask

`ifdef LLC_SWEEP_TIMEOUT_EN
  task automatic test_timeout();
    start_sweep(1'b0);
    tick();
    repeat (7) tick();
    checks++; if ({busy, sweep_err} !== 2'b10) begin failures++; $display("FAIL t6_pre got=%b exp=10", {busy, sweep_err}); end
    tick();
    checks++; if ({busy, sweep_err, rst_stall, sweep_done, set} !== 6'b0_1_0_0_00) begin failures++; $display("FAIL t6_abort got=%b exp=010000", {busy, sweep_err, rst_stall, sweep_done, set}); end
    norm_req_valid = 1'b1;
    tick();
    norm_req_valid = 1'b0;
    tick();
    pass_done = 1'b1;
    tick();
    pass_done = 1'b0;
    checks++; if ({busy, sweep_err} !== 2'b01) begin failures++; $display("FAIL t6_sticky got=%b exp=01", {busy, sweep_err}); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_sweep();
    test_tie();
    test_flush_clr_filter();
    test_retry();
    test_mid_sweep_reset();
`ifdef LLC_SWEEP_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
